adc_lvds_emulator: RTL

ADC_LVDS_EMULATOR -- requirements
Module: adc_lvds_emulator

---
 rtl/adc_lvds_emulator_pkg.sv | 28 ++
 rtl/adc_lane_serializer.sv | 42 ++++
 rtl/adc_lvds_emulator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/adc_lvds_emulator_pkg.sv
// ============================================================================
// adc_lvds_emulator_pkg : shared FSM encoding and frame constants
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_lvds_emulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int                      FRAME_PHASES      = 3;
  localparam logic [1:0]              LAST_PHASE        = 2'd2;
  // Bit p is the frame clock level during phase p.
  localparam logic [FRAME_PHASES-1:0] FRAME_CLK_PATTERN = 3'b011;
  localparam int                      FRAME_CNT_W       = 16;

  function automatic logic [1:0] phase_after(input logic [1:0] p);
    return (p == LAST_PHASE) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_lane_serializer.sv
// ============================================================================
// adc_lane_serializer : one channel, LANES x 3-bit MSB-first shift registers
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_lane_serializer
  import adc_lvds_emulator_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         load,
  input  logic [FRAME_PHASES*LANES-1:0] data,
  output logic [LANES-1:0]             lanes
);

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [FRAME_PHASES-1:0] sreg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sreg <= '0;
        end else if (clear) begin
          sreg <= '0;
        end else if (load) begin
          sreg <= data[FRAME_PHASES*k +: FRAME_PHASES];
        end else begin
          sreg <= {sreg[FRAME_PHASES-2:0], 1'b0};
        end
      end

      assign lanes[k] = sreg[FRAME_PHASES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/adc_lvds_emulator.sv
// ============================================================================
// adc_lvds_emulator : 3-bit-per-frame LVDS ADC emulator for an I/Q pair.
// Optional ramp test pattern via macro ADC_EMU_RAMP_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module adc_lvds_emulator
  import adc_lvds_emulator_pkg::*;
#(
  parameter int SAMPLEWIDTH = 12,
  parameter int LANES       = 4
) (
  input  logic                   i_lvds_bitClk,
  input  logic                   i_rstn,
  input  logic                   i_en,
`ifdef ADC_EMU_RAMP_EN
  input  logic                   i_patternSel,
`endif
  input  logic [SAMPLEWIDTH-1:0] i_smpI,
  input  logic [SAMPLEWIDTH-1:0] i_smpQ,
  input  logic                   i_smpValid,
  output logic                   o_smpReady,
  output logic                   o_lvds_frameClk,
  output logic [LANES-1:0]       o_lvds_dataI,
  output logic [LANES-1:0]       o_lvds_dataQ,
  output logic                   o_underrun,
  output logic [FRAME_CNT_W-1:0] o_frameCount
);

  generate
    if (SAMPLEWIDTH != FRAME_PHASES * LANES) begin : g_width_check
      $error("SAMPLEWIDTH must equal 3*LANES");
    end
  endgenerate

  logic [1:0]             rst_sync;
  logic                   rst_n;
  state_t                 state;
  logic [1:0]             phase;
  logic                   frame_clk;
  logic                   ready;
  logic                   underrun;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic [SAMPLEWIDTH-1:0] held_i;
  logic [SAMPLEWIDTH-1:0] held_q;
  logic [SAMPLEWIDTH-1:0] load_i;
  logic [SAMPLEWIDTH-1:0] load_q;
  logic                   load_pt;
  logic                   miss;
  logic                   ser_clear;

  // Assertion is immediate; release reaches the logic two edges later.
  always_ff @(posedge i_lvds_bitClk or negedge i_rstn) begin
    if (!i_rstn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign load_pt   = (state == ST_LEAD || state == ST_RUN) && (phase == LAST_PHASE);
  assign ser_clear = (state == ST_IDLE) || (state == ST_DRAIN);

`ifdef ADC_EMU_RAMP_EN
  logic [SAMPLEWIDTH-1:0] ramp;

  // Held at zero while idle so the first loaded ramp value is 0.
  always_ff @(posedge i_lvds_bitClk or negedge rst_n) begin
    if (!rst_n)                ramp <= '0;
    else if (state == ST_IDLE) ramp <= '0;
    else if (load_pt)          ramp <= ramp + 1'b1;
  end

  assign load_i = i_patternSel ? ramp  : (i_smpValid ? i_smpI : held_i);
  assign load_q = i_patternSel ? ~ramp : (i_smpValid ? i_smpQ : held_q);
  assign miss   = load_pt && !i_smpValid && !i_patternSel;
`else
  assign load_i = i_smpValid ? i_smpI : held_i;
  assign load_q = i_smpValid ? i_smpQ : held_q;
  assign miss   = load_pt && !i_smpValid;
`endif

  always_ff @(posedge i_lvds_bitClk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      phase       <= LAST_PHASE;
      frame_clk   <= 1'b0;
      ready       <= 1'b0;
      underrun    <= 1'b0;
      frame_count <= '0;
      held_i      <= '0;
      held_q      <= '0;
    end else begin
      if (load_pt && i_smpValid) begin
        held_i <= i_smpI;
        held_q <= i_smpQ;
      end
      if (miss) underrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (i_en) begin
            state     <= ST_LEAD;
            phase     <= 2'd0;
            frame_clk <= FRAME_CLK_PATTERN[0];
          end
        end
        ST_LEAD, ST_RUN: begin
          phase     <= phase_after(phase);
          frame_clk <= FRAME_CLK_PATTERN[phase_after(phase)];
          ready     <= (phase == 2'd1);
          if (phase == LAST_PHASE) begin
            state <= ST_RUN;
            if (state == ST_RUN) frame_count <= frame_count + 1'b1;
          end else if (phase == 2'd1 && state == ST_RUN && !i_en) begin
            // Stop request: the upcoming load point is skipped.
            state <= ST_DRAIN;
            ready <= 1'b0;
          end
        end
        ST_DRAIN: begin
          state       <= ST_IDLE;
          phase       <= LAST_PHASE;
          frame_clk   <= 1'b0;
          frame_count <= frame_count + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  adc_lane_serializer #(.LANES(LANES)) u_ser_i (
    .clk   (i_lvds_bitClk),
    .rst_n (rst_n),
    .clear (ser_clear),
    .load  (load_pt),
    .data  (load_i),
    .lanes (o_lvds_dataI)
  );

  adc_lane_serializer #(.LANES(LANES)) u_ser_q (
    .clk   (i_lvds_bitClk),
    .rst_n (rst_n),
    .clear (ser_clear),
    .load  (load_pt),
    .data  (load_q),
    .lanes (o_lvds_dataQ)
  );

  assign o_smpReady      = ready;
  assign o_lvds_frameClk = frame_clk;
  assign o_underrun      = underrun;
  assign o_frameCount    = frame_count;

endmodule

`default_nettype wire
